// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: start detection, edge/bit counting, checker strobes, data_valid.
// Optional UART_RX_ERR_CNT_EN adds err_cnt, a saturating count of bad or aborted frames.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  start_glitch,
    input  logic                  parity_error,
    input  logic                  stop_error,
    output logic                  rx_check_en,
    output logic                  data_sample_en,
    output logic                  start_check_en,
    output logic                  deser_en,
    output logic                  par_check_en,
    output logic                  stop_check_en,
    output logic                  data_valid,
`ifdef UART_RX_ERR_CNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_q, edge_d;
    logic [3:0]              bit_q, bit_d;
    logic [PRESCALE_W-1:0]   chk_val, end_val;
    logic                    at_chk, at_end, in_frame, last_bit;

    // Sample point sits after the 3-sample majority window.
    assign chk_val  = (prescale >> 1) + PRESCALE_W'(2);
    assign end_val  = prescale - PRESCALE_W'(1);
    assign at_chk   = (edge_q == chk_val);
    assign at_end   = (edge_q == end_val);
    assign last_bit = (bit_q == 4'(DATA_WIDTH - 1));
    assign in_frame = (state_q == StStart) || (state_q == StData) ||
                      (state_q == StParity) || (state_q == StStop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            edge_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        edge_d  = '0;
        bit_d   = '0;
        if (in_frame) begin
            edge_d = at_end ? '0 : edge_q + PRESCALE_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (!serial_in) state_d = StStart;
            end
            StStart: begin
                if (at_end) state_d = start_glitch ? StIdle : StData;
            end
            StData: begin
                bit_d = bit_q;
                if (at_end) begin
                    if (last_bit) begin
                        bit_d   = '0;
                        state_d = par_en ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (at_end) state_d = StStop;
            end
            StStop: begin
                // Leave half a bit early so a back-to-back start edge is not missed;
                // DONE occupies the CHK+1 slot, when the stop flag has just registered.
                if (at_chk) begin
                    state_d = StDone;
                    edge_d  = '0;
                end
            end
            StDone: begin
                state_d = serial_in ? StIdle : StStart;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_check_en    = (state_q == StStart) && (edge_q == '0);
    assign data_sample_en = in_frame;
    assign start_check_en = (state_q == StStart) && at_chk;
    assign deser_en       = (state_q == StData) && at_chk;
    assign par_check_en   = (state_q == StParity) && at_chk;
    assign stop_check_en  = (state_q == StStop) && at_chk;
    assign data_valid     = (state_q == StDone) && !parity_error && !stop_error;
    assign edge_cnt       = edge_q;
    assign bit_cnt        = bit_q;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    assign err_evt = ((state_q == StDone) && (parity_error || stop_error)) ||
                     ((state_q == StStart) && at_end && start_glitch);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
